motoro_commutation_seq: RTL and testbench

//   Six-step (trapezoidal) commutation sequencer for the 3-phase bridge in motoro301_top.

---
 rtl/motoro_pkg.sv | 47 ++++
 rtl/motoro_commutation_seq_if.sv | 27 ++
 rtl/motoro_step_timer.sv | 46 ++++
 rtl/motoro_commutation_seq.sv | 106 ++++++++++
 tb/tb_motoro_commutation_seq.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/motoro_pkg.sv
// Shared types and drive-table helpers for the six-step commutation sequencer.
package motoro_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDead,
        StDrive,
        StFault
    } state_e;

    // High-side gate per step, bits {C,B,A}
    function automatic logic [2:0] drive_hi(logic [2:0] idx);
        logic [2:0] g;
        g = 3'b000;
        case (idx)
            3'd0, 3'd1: g = 3'b001;
            3'd2, 3'd3: g = 3'b010;
            3'd4, 3'd5: g = 3'b100;
            default:    g = 3'b000;
        endcase
        return g;
    endfunction

    // Low-side gate per step, bits {C,B,A}
    function automatic logic [2:0] drive_lo(logic [2:0] idx);
        logic [2:0] g;
        g = 3'b000;
        case (idx)
            3'd0, 3'd5: g = 3'b010;
            3'd1, 3'd2: g = 3'b100;
            3'd3, 3'd4: g = 3'b001;
            default:    g = 3'b000;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] next_step(logic [2:0] idx, logic dir);
        logic [2:0] n;
        if (!dir) begin
            n = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            n = (idx == 3'd0 || idx > 3'd5) ? 3'd5 : idx - 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/motoro_commutation_seq_if.sv
// Control/gate bundle between the register block (master) and the sequencer (slave).
interface motoro_commutation_seq_if #(
    parameter int unsigned STEP_W = 24
);
    logic              en;
    logic              dir;
    logic [STEP_W-1:0] step_period;
    logic              pwm_in;
    logic              fault;
    logic              fault_clr;
    logic [2:0]        gate_hi;
    logic [2:0]        gate_lo;
    logic [2:0]        step_idx;
    logic              step_tick;
    logic              running;
    logic              fault_latched;

    modport master (
        output en, dir, step_period, pwm_in, fault, fault_clr,
        input  gate_hi, gate_lo, step_idx, step_tick, running, fault_latched
    );

    modport slave (
        input  en, dir, step_period, pwm_in, fault, fault_clr,
        output gate_hi, gate_lo, step_idx, step_tick, running, fault_latched
    );
endinterface

// File: rtl/motoro_step_timer.sv
// Per-step counter: samples and clamps the period at step start, flags end of dead time
// and the terminal count of the step.
module motoro_step_timer #(
    parameter int unsigned STEP_W    = 24,
    parameter int unsigned DT_CYCLES = 25
) (
    input  logic              clk50mhz,
    input  logic              nReset,
    input  logic              start,
    input  logic [STEP_W-1:0] period,
    output logic              dt_done,
    output logic              term
);
    localparam logic [STEP_W-1:0] MinPeriod = STEP_W'(DT_CYCLES + 1);
    localparam logic [STEP_W-1:0] DtLast    = STEP_W'(DT_CYCLES - 1);
    localparam logic [STEP_W-1:0] One       = STEP_W'(1);

    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] len_q, len_d;

    assign term    = (cnt_q == len_q - One);
    assign dt_done = (cnt_q == DtLast);

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q + One;
        if (start) begin
            // Clamp keeps at least one DRIVE cycle after the dead time
            len_d = (period < MinPeriod) ? MinPeriod : period;
            cnt_d = '0;
        end else if (term) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
            len_q <= MinPeriod;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/motoro_commutation_seq.sv
// Six-step commutation sequencer: FSM, step index, fault latch and registered gate outputs.
module motoro_commutation_seq
    import motoro_pkg::*;
#(
    parameter int unsigned STEP_W    = 24,
    parameter int unsigned DT_CYCLES = 25
) (
    input logic                     clk50mhz,
    input logic                     nReset,
    motoro_commutation_seq_if.slave bus
);
    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] gate_hi_q, gate_hi_d;
    logic [2:0] gate_lo_q, gate_lo_d;
    logic       tick_q, tick_d;
    logic       running_q, running_d;
    logic       fault_latched_q, fault_latched_d;
    logic       start, dt_done, term;

    motoro_step_timer #(
        .STEP_W   (STEP_W),
        .DT_CYCLES(DT_CYCLES)
    ) u_timer (
        .clk50mhz(clk50mhz),
        .nReset  (nReset),
        .start   (start),
        .period  (bus.step_period),
        .dt_done (dt_done),
        .term    (term)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = 1'b0;
        if (bus.fault) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.en && !fault_latched_q) state_d = StDead;
                end
                StDead: begin
                    if (!bus.en)      state_d = StIdle;
                    else if (dt_done) state_d = StDrive;
                end
                StDrive: begin
                    if (!bus.en) begin
                        state_d = StIdle;
                    end else if (term) begin
                        state_d = StDead;
                        idx_d   = next_step(idx_q, bus.dir);
                        tick_d  = 1'b1;
                    end
                end
                StFault: begin
                    if (bus.fault_clr) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Every entry into DEAD begins a new step, including the first one out of IDLE
    assign start = (state_d == StDead) && (state_q != StDead);

    always_comb begin
        gate_hi_d = 3'b000;
        gate_lo_d = 3'b000;
        if (state_d == StDrive) begin
            gate_hi_d = drive_hi(idx_d) & {3{bus.pwm_in}};
            gate_lo_d = drive_lo(idx_d);
        end
        running_d       = (state_d == StDead) || (state_d == StDrive);
        fault_latched_d = (state_d == StFault);
    end

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            state_q         <= StIdle;
            idx_q           <= 3'd0;
            gate_hi_q       <= 3'b000;
            gate_lo_q       <= 3'b000;
            tick_q          <= 1'b0;
            running_q       <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            gate_hi_q       <= gate_hi_d;
            gate_lo_q       <= gate_lo_d;
            tick_q          <= tick_d;
            running_q       <= running_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign bus.gate_hi       = gate_hi_q;
    assign bus.gate_lo       = gate_lo_q;
    assign bus.step_idx      = idx_q;
    assign bus.step_tick     = tick_q;
    assign bus.running       = running_q;
    assign bus.fault_latched = fault_latched_q;

endmodule

// File: tb/tb_motoro_commutation_seq.sv
// Bench for the commutation sequencer: cycle model feeding a scoreboard queue, a segment
// table for the stepping behaviour, and hand sequences for fault, PWM and reset corners.
module tb_motoro_commutation_seq;
    localparam int unsigned STEP_W = 24;
    localparam int          DT     = 25;

    logic clk50mhz = 1'b0;
    logic nReset   = 1'b0;
    always #10 clk50mhz = ~clk50mhz;

    motoro_commutation_seq_if #(.STEP_W(STEP_W)) bus ();

    motoro_commutation_seq #(
        .STEP_W   (STEP_W),
        .DT_CYCLES(DT)
    ) dut (
        .clk50mhz(clk50mhz),
        .nReset  (nReset),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] hi;
        logic [2:0] lo;
        logic [2:0] idx;
        logic       tick;
        logic       run;
        logic       fl;
    } exp_t;

    typedef struct {
        logic en;
        logic dir;
        int   period;
        int   cycles;
        int   exp_idx;
    } seg_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_no = 0;

    // Reference model: 0 idle, 1 dead, 2 drive, 3 fault
    int   m_st = 0, m_idx = 0, m_age = 0, m_len = DT + 1;
    exp_t m_out;

    function automatic logic [2:0] ref_hi(int i);
        if (i <= 1) return 3'b001;
        if (i <= 3) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ref_lo(int i);
        if (i == 0 || i == 5) return 3'b010;
        if (i == 1 || i == 2) return 3'b100;
        return 3'b001;
    endfunction

    function automatic int clamp_p(int p);
        return (p < DT + 1) ? DT + 1 : p;
    endfunction

    task automatic model_edge();
        int   nst;
        int   nidx;
        logic tk;
        nst  = m_st;
        nidx = m_idx;
        tk   = 1'b0;
        if (!nReset) begin
            m_st = 0; m_idx = 0; m_age = 0;
            m_out.hi = 3'b000; m_out.lo = 3'b000; m_out.idx = 3'd0;
            m_out.tick = 1'b0; m_out.run = 1'b0; m_out.fl = 1'b0;
            return;
        end
        if (bus.fault) begin
            nst = 3;
        end else if (m_st == 0) begin
            if (bus.en) begin
                nst = 1; m_age = 0; m_len = clamp_p(int'(bus.step_period));
            end
        end else if (m_st == 3) begin
            if (bus.fault_clr) nst = 0;
        end else if (!bus.en) begin
            nst = 0;
        end else if (m_age == m_len - 1) begin
            nidx  = bus.dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
            tk    = 1'b1;
            nst   = 1;
            m_age = 0;
            m_len = clamp_p(int'(bus.step_period));
        end else begin
            m_age = m_age + 1;
            nst   = (m_age >= DT) ? 2 : 1;
        end
        m_out.hi   = (nst == 2) ? (ref_hi(nidx) & {3{bus.pwm_in}}) : 3'b000;
        m_out.lo   = (nst == 2) ? ref_lo(nidx) : 3'b000;
        m_out.idx  = 3'(nidx);
        m_out.tick = tk;
        m_out.run  = (nst == 1 || nst == 2);
        m_out.fl   = (nst == 3);
        m_st  = nst;
        m_idx = nidx;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // One clock: predict, push, clock, then pop and compare #1 after the edge
    task automatic cycle();
        exp_t e;
        model_edge();
        sb_q.push_back(m_out);
        @(posedge clk50mhz);
        #1;
        edge_no++;
        e = sb_q.pop_front();
        checks++;
        if (bus.gate_hi !== e.hi || bus.gate_lo !== e.lo || bus.step_idx !== e.idx ||
            bus.step_tick !== e.tick || bus.running !== e.run || bus.fault_latched !== e.fl) begin
            failures++;
            $display("FAIL scoreboard edge %0d: got hi=%b lo=%b idx=%0d tick=%b run=%b fl=%b, expected hi=%b lo=%b idx=%0d tick=%b run=%b fl=%b",
                     edge_no, bus.gate_hi, bus.gate_lo, bus.step_idx, bus.step_tick, bus.running,
                     bus.fault_latched, e.hi, e.lo, e.idx, e.tick, e.run, e.fl);
        end
        checks++;
        assert (((bus.gate_hi & bus.gate_lo) == 3'b000) && $onehot0(bus.gate_hi) &&
                $onehot0(bus.gate_lo))
        else begin
            failures++;
            $display("FAIL invariant edge %0d: got hi=%b lo=%b, expected disjoint one-hot",
                     edge_no, bus.gate_hi, bus.gate_lo);
        end
    endtask

    task automatic wait_drive(string name, int limit);
        int n;
        n = 0;
        while (bus.gate_lo == 3'b000 && n < limit) begin
            cycle();
            n++;
        end
        chk(name, int'(bus.gate_lo != 3'b000), 1);
    endtask

    seg_t segs[8];
    int   tick_at[$];
    int   p;

    initial begin
        bus.en = 1'b1; bus.dir = 1'b0; bus.step_period = STEP_W'(100);
        bus.pwm_in = 1'b1; bus.fault = 1'b1; bus.fault_clr = 1'b0;

        // Held in reset with en and fault active: everything stays at zero
        repeat (4) cycle();
        chk("reset_idx", int'(bus.step_idx), 0);
        chk("reset_run", int'(bus.running), 0);

        nReset = 1'b1; bus.en = 1'b0; bus.fault = 1'b0;
        repeat (2) cycle();
        chk("idle_fl", int'(bus.fault_latched), 0);

        segs[0] = '{1'b1, 1'b0, 100, 650, 0};
        segs[1] = '{1'b1, 1'b1, 100, 100, 5};
        segs[2] = '{1'b1, 1'b1, 100, 100, 4};
        segs[3] = '{1'b1, 1'b1, 100, 100, 3};
        segs[4] = '{1'b1, 1'b0, 100, 30, 3};
        segs[5] = '{1'b1, 1'b0, 100, 70, 4};
        segs[6] = '{1'b1, 1'b0, 10, 100, 0};
        segs[7] = '{1'b1, 1'b0, 0, 60, 3};

        edge_no = 0;
        foreach (segs[s]) begin
            bus.en = segs[s].en; bus.dir = segs[s].dir;
            bus.step_period = STEP_W'(segs[s].period);
            for (int c = 0; c < segs[s].cycles; c++) begin
                cycle();
                if (bus.step_tick) tick_at.push_back(edge_no);
                if (s == 0 && edge_no == 25) chk("dead_gates", int'({bus.gate_hi, bus.gate_lo}), 0);
                if (s == 0 && edge_no == 26) begin
                    chk("first_hi", int'(bus.gate_hi), 1);
                    chk("first_lo", int'(bus.gate_lo), 2);
                end
            end
            chk($sformatf("seg%0d_idx", s), int'(bus.step_idx), segs[s].exp_idx);
            chk($sformatf("seg%0d_run", s), int'(bus.running), 1);
        end

        // 100-clock steps until edge 1101, then clamped 26-clock steps
        chk("tick_count", tick_at.size(), 15);
        for (int i = 1; i < tick_at.size(); i++)
            chk($sformatf("tick_gap%0d", i), tick_at[i] - tick_at[i-1], (i <= 10) ? 100 : 26);

        // Fault mid-DRIVE, clear blocked while fault held, then clean clear and restart
        bus.step_period = STEP_W'(100);
        wait_drive("reach_drive1", 200);
        bus.fault = 1'b1;
        cycle();
        chk("fault_gates", int'({bus.gate_hi, bus.gate_lo}), 0);
        chk("fault_fl", int'(bus.fault_latched), 1);
        chk("fault_run", int'(bus.running), 0);
        bus.fault_clr = 1'b1;
        repeat (3) cycle();
        chk("fault_wins", int'(bus.fault_latched), 1);
        bus.fault = 1'b0;
        cycle();
        chk("clr_fl", int'(bus.fault_latched), 0);
        chk("clr_idle", int'(bus.running), 0);
        bus.fault_clr = 1'b0;
        cycle();
        chk("restart_run", int'(bus.running), 1);

        // PWM chopping of the high side, one clock late
        wait_drive("reach_drive2", 60);
        for (int k = 0; k < 30; k++) begin
            bus.pwm_in = ((k / 3) % 2) == 0;
            p = int'(bus.pwm_in);
            cycle();
            if (bus.gate_lo != 3'b000) chk("pwm_follow", int'(bus.gate_hi != 3'b000), p);
        end
        bus.pwm_in = 1'b1;

        // Asynchronous reset in the middle of a step
        @(negedge clk50mhz);
        nReset = 1'b0;
        #1;
        chk("async_gates", int'({bus.gate_hi, bus.gate_lo}), 0);
        chk("async_idx", int'(bus.step_idx), 0);
        chk("async_run", int'(bus.running), 0);
        repeat (2) cycle();
        nReset = 1'b1; bus.en = 1'b0;
        repeat (2) cycle();
        chk("no_resume", int'(bus.running), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
